bkm_csd_multi_monitor: RTL and testbench
========================================

Name: bkm_csd_multi_monitor

Overview:
Parametrised successor to the BKM step monitor. Converts NCH channels of CSD-encoded BKM step outputs to two's-complement results through a 2-stage pipeline with valid tracking. Each result is checked against per-channel expected values, and illegal-digit, mismatch and sample counts are accumulated inside a start/stop measurement window. Instantiated in xfire_fpu_bkm verification benches after the bkm_steps DUT.

Parameters:
WD, 64, data width per channel in binary digits (CSD input is 2*WD bits per channel)
NCH, 2, number of channels (2 = X,Y)
CNTW, 16, width of sample and error counters

Ports:
clk  input  1  clock, all logic rising-edge
srst  input  1  synchronous active-high reset
enable  input  1  pipeline advance; low = all pipeline and FSM state holds
in_valid  input  1  csd_in/exp_in valid this cycle
csd_in  input  NCH*2*WD  channel c at [c*2*WD +: 2*WD]
exp_in  input  NCH*WD  expected binary result, channel c at [c*WD +: WD]
exp_chk  input  NCH  per-channel compare enable, sampled with in_valid
start  input  1  open measurement window
stop  input  1  close measurement window
res_out  output  NCH*WD  converted results, channel c at [c*WD +: WD]
res_valid  output  1  res_out/mismatch/illegal valid
mismatch  output  NCH  res != exp for channels with exp_chk set
illegal  output  NCH  channel contained at least one 11 digit
smp_cnt  output  CNTW  counted valid samples, saturating
err_cnt  output  CNTW  counted mismatching channel-samples, saturating
busy  output  1  FSM in RUN or FLUSH
done  output  1  FSM in DONE

Behaviour:
- Reset (srst=1 at clk edge, overrides all, including mid-window): every output 0, all pipeline valids and tags 0, FSM=IDLE.
- CSD digit i of a channel = {csd[2i+1], csd[2i]}: 00->0, 01->+1, 10->-1, 11->illegal, contributes 0 and sets illegal.
- Conversion: P = bits with digit 01, N = bits with digit 10; res = (P - N) mod 2^WD, WD-bit two's complement. No overflow flag; wrap is intended.
- Pipeline, advancing only when enable=1:
  - S1 registers P, N, illegal, exp, exp_chk, in_valid, and tag = (state==RUN at sample).
  - S2 registers res, mismatch[c] = exp_chk[c] & (res_c != exp_c), illegal, valid, and tag.
- Latency: 2 enabled cycles from in_valid to res_valid. res_valid=0 implies mismatch=0 and illegal=0; res_out holds its last value.
- enable=0: S1, S2, outputs, counters and FSM all hold; start/stop are ignored.
- FSM (enable=1 only):
  - IDLE: start -> RUN, clearing smp_cnt and err_cnt. stop ignored.
  - RUN: stop -> FLUSH. start ignored. start and stop in the same cycle: stop wins.
  - FLUSH: -> DONE when neither S1 nor S2 holds a valid tagged entry. start ignored.
  - DONE: start -> RUN, clearing counters. Counters hold otherwise.
  - start and stop together in IDLE or DONE: start wins.
- Counting: on an enabled cycle where S2 valid and tag are both set:
  - smp_cnt += 1.
  - err_cnt += popcount(mismatch), up to NCH.
  - Both saturate at 2^CNTW-1 and never wrap.
- Samples entering in FLUSH/DONE/IDLE are converted and output but never counted. Samples tagged in RUN are counted even after stop.

Test Plan:
- Reset then idle: srst 1 cycle, enable=1, no inputs -> all outputs 0, busy=0, done=0.
- Conversion WD=8, ch0 digits +1 at bit0 and -1 at bit3 -> res_out ch0 = 0xF9 (-7); all-zero CSD -> 0x00; illegal ch1 digit 0 = 11 -> illegal[1]=1, res ch1 = 0. All appear exactly 2 enabled cycles after in_valid.
- Window: start, 5 valid samples with ch1 exp wrong on 2 of them, stop on the cycle after the last sample -> busy through FLUSH, done after drain, smp_cnt=5, err_cnt=2. A sample injected after stop is output but not counted.
- Stall: enable low for 3 cycles with 2 samples in flight -> res_valid timing shifts by 3 cycles, values unchanged, FSM does not leave FLUSH during the stall.
- Saturation CNTW=4: 20 counted samples, all NCH=2 mismatching -> smp_cnt=15, err_cnt=15.
- srst asserted in RUN with samples in flight -> next cycle all zero, IDLE, no res_valid emerges from the flushed pipeline.

Source files
------------

// File: rtl/bkm_csd_multi_monitor.sv
// Multi-channel CSD to two's-complement monitor for BKM step outputs.
// Two-stage conversion pipeline with compare, illegal-digit flags and windowed counters.
module bkm_csd_multi_monitor #(
  parameter int WD   = 64,
  parameter int NCH  = 2,
  parameter int CNTW = 16
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  enable,
  input  logic                  in_valid,
  input  logic [NCH*2*WD-1:0]   csd_in,
  input  logic [NCH*WD-1:0]     exp_in,
  input  logic [NCH-1:0]        exp_chk,
  input  logic                  start,
  input  logic                  stop,
  output logic [NCH*WD-1:0]     res_out,
  output logic                  res_valid,
  output logic [NCH-1:0]        mismatch,
  output logic [NCH-1:0]        illegal,
  output logic [CNTW-1:0]       smp_cnt,
  output logic [CNTW-1:0]       err_cnt,
  output logic                  busy,
  output logic                  done
);

  // Handshake: in_valid qualifies csd_in/exp_in/exp_chk on an enabled edge; there is no
  // backpressure. res_valid qualifies res_out/mismatch/illegal two enabled edges later.

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  state_t state_q, state_d;
  logic   clr_cnt;
  logic   pending;

  // Stage-0 digit decode
  logic [NCH-1:0][WD-1:0] p_d, n_d;
  logic [NCH-1:0]         ill_d;

  // Stage 1
  logic [NCH-1:0][WD-1:0] p1_q, n1_q;
  logic [NCH-1:0]         ill1_q;
  logic [NCH*WD-1:0]      exp1_q;
  logic [NCH-1:0]         chk1_q;
  logic                   v1_q, t1_q;

  // Stage 2
  logic [NCH-1:0][WD-1:0] res_d;
  logic [NCH-1:0]         mm_d;
  logic [NCH-1:0][WD-1:0] res2_q;
  logic [NCH-1:0]         mm2_q, ill2_q;
  logic                   v2_q, t2_q;

  // Counters
  logic [CNTW-1:0] smp_q, err_q;
  logic [CNTW:0]   pop;
  logic [CNTW:0]   err_sum;

  always_comb begin
    p_d   = '0;
    n_d   = '0;
    ill_d = '0;
    for (int c = 0; c < NCH; c++) begin
      for (int i = 0; i < WD; i++) begin
        p_d[c][i] = ~csd_in[c*2*WD + 2*i + 1] &  csd_in[c*2*WD + 2*i];
        n_d[c][i] =  csd_in[c*2*WD + 2*i + 1] & ~csd_in[c*2*WD + 2*i];
        ill_d[c]  = ill_d[c] | (csd_in[c*2*WD + 2*i + 1] & csd_in[c*2*WD + 2*i]);
      end
    end
  end

  // Tag marks samples accepted while the window is open; only those are ever counted.
  always_ff @(posedge clk) begin
    if (srst) begin
      p1_q   <= '0;
      n1_q   <= '0;
      ill1_q <= '0;
      exp1_q <= '0;
      chk1_q <= '0;
      v1_q   <= 1'b0;
      t1_q   <= 1'b0;
    end else if (enable) begin
      p1_q   <= p_d;
      n1_q   <= n_d;
      ill1_q <= ill_d;
      exp1_q <= exp_in;
      chk1_q <= exp_chk;
      v1_q   <= in_valid;
      t1_q   <= (state_q == RUN);
    end
  end

  always_comb begin
    res_d = '0;
    mm_d  = '0;
    for (int c = 0; c < NCH; c++) begin
      res_d[c] = p1_q[c] - n1_q[c];
      mm_d[c]  = v1_q & chk1_q[c] & (res_d[c] != exp1_q[c*WD +: WD]);
    end
  end

  // res_out keeps the last valid result; flags are forced low when nothing is valid.
  always_ff @(posedge clk) begin
    if (srst) begin
      res2_q <= '0;
      mm2_q  <= '0;
      ill2_q <= '0;
      v2_q   <= 1'b0;
      t2_q   <= 1'b0;
    end else if (enable) begin
      if (v1_q) res2_q <= res_d;
      mm2_q  <= mm_d;
      ill2_q <= v1_q ? ill1_q : '0;
      v2_q   <= v1_q;
      t2_q   <= t1_q;
    end
  end

  assign pending = (v1_q & t1_q) | (v2_q & t2_q);

  always_comb begin
    state_d = state_q;
    clr_cnt = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          clr_cnt = 1'b1;
        end
      end
      RUN: begin
        if (stop) state_d = FLUSH;
      end
      FLUSH: begin
        if (!pending) state_d = DONE;
      end
      DONE: begin
        if (start) begin
          state_d = RUN;
          clr_cnt = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) state_q <= IDLE;
    else if (enable) state_q <= state_d;
  end

  always_comb begin
    pop = '0;
    for (int c = 0; c < NCH; c++) pop = pop + (CNTW+1)'(mm2_q[c]);
    err_sum = {1'b0, err_q} + pop;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      smp_q <= '0;
      err_q <= '0;
    end else if (enable) begin
      if (clr_cnt) begin
        smp_q <= '0;
        err_q <= '0;
      end else if (v2_q && t2_q) begin
        smp_q <= (smp_q == CNT_MAX) ? smp_q : smp_q + CNTW'(1);
        err_q <= (err_sum > {1'b0, CNT_MAX}) ? CNT_MAX : err_sum[CNTW-1:0];
      end
    end
  end

  assign res_out   = res2_q;
  assign res_valid = v2_q;
  assign mismatch  = mm2_q;
  assign illegal   = ill2_q;
  assign smp_cnt   = smp_q;
  assign err_cnt   = err_q;
  assign busy      = (state_q == RUN) || (state_q == FLUSH);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_bkm_csd_multi_monitor.sv
// Bench for bkm_csd_multi_monitor at WD=8, NCH=2, CNTW=4: directed scenarios plus random
// traffic, compared every cycle against an arithmetic reference model.
module tb_bkm_csd_multi_monitor;

  localparam int WD   = 8;
  localparam int NCH  = 2;
  localparam int CNTW = 4;
  localparam int CMAX = 15;

  localparam int PH_IDLE  = 0;
  localparam int PH_RUN   = 1;
  localparam int PH_FLUSH = 2;
  localparam int PH_DONE  = 3;

  logic                clk;
  logic                srst;
  logic                enable;
  logic                in_valid;
  logic [NCH*2*WD-1:0] csd_in;
  logic [NCH*WD-1:0]   exp_in;
  logic [NCH-1:0]      exp_chk;
  logic                start;
  logic                stop;
  logic [NCH*WD-1:0]   res_out;
  logic                res_valid;
  logic [NCH-1:0]      mismatch;
  logic [NCH-1:0]      illegal;
  logic [CNTW-1:0]     smp_cnt;
  logic [CNTW-1:0]     err_cnt;
  logic                busy;
  logic                done;

  bkm_csd_multi_monitor #(.WD(WD), .NCH(NCH), .CNTW(CNTW)) dut (
    .clk(clk), .srst(srst), .enable(enable), .in_valid(in_valid),
    .csd_in(csd_in), .exp_in(exp_in), .exp_chk(exp_chk),
    .start(start), .stop(stop), .res_out(res_out), .res_valid(res_valid),
    .mismatch(mismatch), .illegal(illegal), .smp_cnt(smp_cnt), .err_cnt(err_cnt),
    .busy(busy), .done(done)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: one entry per enabled edge, {valid, tag, illegal[1:0], mismatch[1:0], res[15:0]}
  logic [21:0] exp_q[$];
  logic [15:0] m_res;
  int          m_smp, m_err, m_phase;
  int          n_checks, n_fail;

  function automatic logic [7:0] csd_to_bin(input logic [15:0] c);
    int acc;
    acc = 0;
    for (int i = 0; i < WD; i++) begin
      if (c[2*i +: 2] == 2'b01) acc += (1 << i);
      if (c[2*i +: 2] == 2'b10) acc -= (1 << i);
    end
    return acc[7:0];
  endfunction

  function automatic bit csd_bad(input logic [15:0] c);
    bit b;
    b = 0;
    for (int i = 0; i < WD; i++) if (c[2*i +: 2] == 2'b11) b = 1;
    return b;
  endfunction

  task automatic model_edge();
    logic [21:0] r;
    logic [15:0] rv;
    logic [1:0]  mmv, illv;
    bit          pend, tg;
    if (srst) begin
      exp_q.delete();
      m_res = '0; m_smp = 0; m_err = 0; m_phase = PH_IDLE;
      return;
    end
    if (!enable) return;
    if (exp_q.size() == 2) begin
      r = exp_q[0];
      if (r[21] && r[20]) begin
        if (m_smp < CMAX) m_smp++;
        m_err = m_err + $countones(r[17:16]);
        if (m_err > CMAX) m_err = CMAX;
      end
    end
    pend = 0;
    foreach (exp_q[k]) if (exp_q[k][21] && exp_q[k][20]) pend = 1;
    tg = (m_phase == PH_RUN);
    case (m_phase)
      PH_IDLE, PH_DONE: if (start) begin m_phase = PH_RUN; m_smp = 0; m_err = 0; end
      PH_RUN:   if (stop) m_phase = PH_FLUSH;
      PH_FLUSH: if (!pend) m_phase = PH_DONE;
      default:  m_phase = PH_IDLE;
    endcase
    for (int c = 0; c < NCH; c++) begin
      rv[c*8 +: 8] = csd_to_bin(csd_in[c*16 +: 16]);
      illv[c] = in_valid & csd_bad(csd_in[c*16 +: 16]);
      mmv[c]  = in_valid & exp_chk[c] & (rv[c*8 +: 8] != exp_in[c*8 +: 8]);
    end
    exp_q.push_back({in_valid, tg, illv, mmv, rv});
    while (exp_q.size() > 2) void'(exp_q.pop_front());
    if (exp_q.size() == 2 && exp_q[0][21]) m_res = exp_q[0][15:0];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    logic [21:0] o;
    o = (exp_q.size() == 2) ? exp_q[0] : 22'd0;
    chk("res_out",   32'(res_out),   32'(m_res));
    chk("res_valid", 32'(res_valid), 32'(o[21]));
    chk("mismatch",  32'(mismatch),  32'(o[17:16]));
    chk("illegal",   32'(illegal),   32'(o[19:18]));
    chk("smp_cnt",   32'(smp_cnt),   32'(m_smp));
    chk("err_cnt",   32'(err_cnt),   32'(m_err));
    chk("busy",      32'(busy),      32'(m_phase == PH_RUN || m_phase == PH_FLUSH));
    chk("done",      32'(done),      32'(m_phase == PH_DONE));
  endtask

  // Driver tasks
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input logic iv, input logic [31:0] c, input logic [15:0] e,
                       input logic [1:0] k, input logic st, input logic sp);
    in_valid = iv; csd_in = c; exp_in = e; exp_chk = k; start = st; stop = sp;
  endtask

  task automatic idle(input int n);
    drive(0, 32'd0, 16'd0, 2'b00, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Valid sample with exp correct except the channels set in bad_mask
  task automatic sample(input logic [31:0] c, input logic [1:0] bad_mask, input logic sp);
    logic [15:0] e;
    for (int ch = 0; ch < NCH; ch++)
      e[ch*8 +: 8] = csd_to_bin(c[ch*16 +: 16]) ^ (bad_mask[ch] ? 8'h01 : 8'h00);
    drive(1, c, e, 2'b11, 0, sp);
    tick();
  endtask

  function automatic logic [31:0] legal_csd();
    logic [31:0] v;
    v = $urandom;
    for (int i = 0; i < 16; i++) if (v[2*i +: 2] == 2'b11) v[2*i +: 2] = 2'b00;
    return v;
  endfunction

  initial begin
    n_checks = 0; n_fail = 0;
    m_res = '0; m_smp = 0; m_err = 0; m_phase = PH_IDLE;
    enable = 1; srst = 1;
    drive(0, 32'd0, 16'd0, 2'b00, 0, 0);

    // Reset then idle
    tick();
    srst = 0;
    idle(3);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_smp", 32'(smp_cnt), 32'd0);

    // Conversion: +1 at bit0, -1 at bit3 -> -7; then illegal digit on ch1
    drive(1, 32'h0000_0081, 16'h00F9, 2'b01, 0, 0);
    tick();
    drive(1, 32'h0003_0000, 16'h0000, 2'b00, 0, 0);
    tick();
    chk("conv_m7", 32'(res_out), 32'h0000_00F9);
    idle(1);
    chk("conv_ill", 32'(illegal), 32'd2);
    chk("conv_zero", 32'(res_out), 32'd0);
    idle(2);

    // Window: 5 samples, ch1 wrong on two, sample after stop not counted
    drive(0, 32'd0, 16'd0, 2'b00, 1, 0);
    tick();
    for (int i = 0; i < 5; i++) sample(legal_csd(), (i == 1 || i == 3) ? 2'b10 : 2'b00, 0);
    idle(0);
    drive(0, 32'd0, 16'd0, 2'b00, 0, 1);
    tick();
    sample(legal_csd(), 2'b11, 0);
    idle(6);
    chk("win_smp", 32'(smp_cnt), 32'd5);
    chk("win_err", 32'(err_cnt), 32'd2);
    chk("win_done", 32'(done), 32'd1);

    // Stall with two samples in flight
    drive(0, 32'd0, 16'd0, 2'b00, 1, 0);
    tick();
    sample(legal_csd(), 2'b01, 0);
    sample(legal_csd(), 2'b00, 1);
    enable = 0;
    drive(1, legal_csd(), 16'h1234, 2'b11, 1, 1);
    for (int i = 0; i < 3; i++) tick();
    chk("stall_busy", 32'(busy), 32'd1);
    enable = 1;
    idle(6);
    chk("stall_smp", 32'(smp_cnt), 32'd2);
    chk("stall_err", 32'(err_cnt), 32'd1);

    // Saturation: 20 samples, both channels mismatching
    drive(0, 32'd0, 16'd0, 2'b00, 1, 0);
    tick();
    for (int i = 0; i < 20; i++) sample(legal_csd(), 2'b11, 0);
    drive(0, 32'd0, 16'd0, 2'b00, 0, 1);
    tick();
    idle(5);
    chk("sat_smp", 32'(smp_cnt), 32'd15);
    chk("sat_err", 32'(err_cnt), 32'd15);

    // Reset mid-window with samples in flight
    drive(0, 32'd0, 16'd0, 2'b00, 1, 0);
    tick();
    sample(legal_csd(), 2'b00, 0);
    sample(legal_csd(), 2'b01, 0);
    srst = 1;
    drive(1, legal_csd(), 16'd0, 2'b11, 0, 0);
    tick();
    srst = 0;
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    idle(3);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] c;
      logic [15:0] e;
      c = $urandom;
      for (int ch = 0; ch < NCH; ch++)
        e[ch*8 +: 8] = ($urandom_range(0, 1) == 0) ? csd_to_bin(c[ch*16 +: 16]) : 8'($urandom);
      srst   = ($urandom_range(0, 59) == 0);
      enable = ($urandom_range(0, 4) != 0);
      drive(($urandom_range(0, 9) < 6), c, e, 2'($urandom),
            ($urandom_range(0, 14) == 0), ($urandom_range(0, 14) == 0));
      tick();
    end
    srst = 0; enable = 1;
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
